// File: rtl/eth_tx_slot.sv
// rtl/eth_tx_slot.sv - GMII transmitter that serialises one frame from the TX slot RAM
//
// Purpose: on tx_start, reads the host-written frame from the TX slot RAM
// (32-bit words, one-cycle read latency) and sends it on GMII as
// preamble, SFD, frame bytes and inter-frame gap. The global counter
// value in the SFD cycle is kept as the TX timestamp.
// Optional feature macro: ETH_TX_CRC_EN - pads short frames to 60 bytes
// and appends the IEEE 802.3 FCS. Without it the host supplies the FCS.
//
// Ports:
//   gmii_tx_clk      in   clock (125 MHz)
//   sys_rst          in   synchronous active-high reset
//   tx_start         in   one-cycle transmit request
//   tx_frame_len     in   [11:0] frame byte count, sampled with tx_start
//   global_counter   in   [63:0] free-running timestamp counter
//   slot_tx_address  out  [10:0] RAM word address
//   slot_tx_q        in   [31:0] RAM read data
//   gmii_txd         out  [7:0] transmit data
//   gmii_tx_en       out  transmit enable
//   tx_busy          out  request accepted, frame or IFG in progress
//   tx_complete      out  pulse at end of IFG, or on a dropped request
//   tx_drop          out  pulse with tx_complete for a rejected request
//   tx_timestamp     out  [63:0] global_counter captured in the SFD cycle

module eth_tx_slot #(
  parameter int MAX_FRAME_LEN = 1518,
  parameter int IFG_CYCLES    = 12,
  parameter int PREAMBLE_LEN  = 7
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic        tx_start,
  input  logic [11:0] tx_frame_len,
  input  logic [63:0] global_counter,
  output logic [10:0] slot_tx_address,
  input  logic [31:0] slot_tx_q,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        tx_busy,
  output logic        tx_complete,
  output logic        tx_drop,
  output logic [63:0] tx_timestamp
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
`ifdef ETH_TX_CRC_EN
    S_PAD      = 3'd4,
    S_FCS      = 3'd5,
`endif
    S_IFG      = 3'd6
  } state_t;

  localparam logic [11:0] MAX_LEN   = 12'(MAX_FRAME_LEN);
  localparam logic [11:0] PRE_LAST  = 12'(PREAMBLE_LEN - 1);
  localparam logic [11:0] IFG_LAST  = 12'(IFG_CYCLES - 1);
  // tx_complete is registered, so it is requested one IFG cycle early
  // (IFG_CYCLES must be at least 2).
  localparam logic [11:0] IFG_PULSE = 12'(IFG_CYCLES - 2);
`ifdef ETH_TX_CRC_EN
  localparam logic [11:0] MIN_LEN   = 12'd60;
`endif

  // The state register names what is on the wire this cycle; the
  // combinational logic computes the byte for the next cycle.
  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] len_q, len_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        complete_q, complete_d;
  logic        drop_q, drop_d;
  logic [63:0] ts_q, ts_d;
`ifdef ETH_TX_CRC_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_word;
`endif
  logic [7:0]  data_byte;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    unique case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

`ifdef ETH_TX_CRC_EN
  // Reflected CRC32 (poly 0x04C11DB7 reversed), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs_word = ~crc_q;
`endif

  // cnt_q holds the index of the byte being computed, so its low bits
  // select the lane of the word currently on slot_tx_q.
  assign data_byte = lane_byte(slot_tx_q, cnt_q[1:0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    txd_d      = 8'h00;
    en_d       = 1'b0;
    busy_d     = busy_q;
    complete_d = 1'b0;
    drop_d     = 1'b0;
    ts_d       = ts_q;
`ifdef ETH_TX_CRC_EN
    crc_d      = crc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (tx_frame_len == 12'd0 || tx_frame_len > MAX_LEN) begin
            complete_d = 1'b1;
            drop_d     = 1'b1;
          end else begin
            state_d = S_PREAMBLE;
            len_d   = tx_frame_len;
            cnt_d   = 12'd0;
            addr_d  = 11'd0;
            txd_d   = 8'h55;
            en_d    = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        en_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = S_SFD;
          txd_d   = 8'hD5;
          cnt_d   = 12'd0;
`ifdef ETH_TX_CRC_EN
          crc_d   = 32'hFFFFFFFF;
`endif
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_SFD,
`ifdef ETH_TX_CRC_EN
      S_PAD,
`endif
      S_DATA: begin
        if (state_q == S_SFD) begin
          ts_d = global_counter;
        end
        if (cnt_q < len_q) begin
          state_d = S_DATA;
          txd_d   = data_byte;
          en_d    = 1'b1;
          cnt_d   = cnt_q + 12'd1;
          // Next word goes out while lane 2 is on the wire, so it is
          // on slot_tx_q exactly when lane 0 of it is needed.
          if (cnt_q[1:0] == 2'd2) begin
            addr_d = addr_q + 11'd1;
          end
`ifdef ETH_TX_CRC_EN
          crc_d = crc32_byte(crc_q, data_byte);
        end else if (cnt_q < MIN_LEN) begin
          state_d = S_PAD;
          en_d    = 1'b1;
          cnt_d   = cnt_q + 12'd1;
          crc_d   = crc32_byte(crc_q, 8'h00);
        end else begin
          // cnt_q is reused as the FCS byte index from here on.
          state_d = S_FCS;
          en_d    = 1'b1;
          txd_d   = fcs_word[7:0];
          cnt_d   = 12'd1;
`else
        end else begin
          state_d = S_IFG;
          cnt_d   = 12'd0;
`endif
        end
      end
`ifdef ETH_TX_CRC_EN
      S_FCS: begin
        if (cnt_q < 12'd4) begin
          en_d  = 1'b1;
          txd_d = lane_byte(fcs_word, cnt_q[1:0]);
          cnt_d = cnt_q + 12'd1;
        end else begin
          state_d = S_IFG;
          cnt_d   = 12'd0;
        end
      end
`endif
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 12'd0;
        end else begin
          cnt_d      = cnt_q + 12'd1;
          complete_d = (cnt_q == IFG_PULSE);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 12'd0;
      len_q      <= 12'd0;
      addr_q     <= 11'd0;
      txd_q      <= 8'h00;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      drop_q     <= 1'b0;
      ts_q       <= 64'd0;
`ifdef ETH_TX_CRC_EN
      crc_q      <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      txd_q      <= txd_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      drop_q     <= drop_d;
      ts_q       <= ts_d;
`ifdef ETH_TX_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign slot_tx_address = addr_q;
  assign gmii_txd        = txd_q;
  assign gmii_tx_en      = en_q;
  assign tx_busy         = busy_q;
  assign tx_complete     = complete_q;
  assign tx_drop         = drop_q;
  assign tx_timestamp    = ts_q;

endmodule

// File: tb/tb_eth_tx_slot.sv
// tb/tb_eth_tx_slot.sv - scoreboard bench for eth_tx_slot
module tb_eth_tx_slot;

  localparam int PRE = 7;
  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        tx_start;
  logic [11:0] tx_frame_len;
  logic [63:0] global_counter;
  logic [10:0] slot_tx_address;
  logic [31:0] slot_tx_q;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        tx_busy;
  logic        tx_complete;
  logic        tx_drop;
  logic [63:0] tx_timestamp;

  always #4 clk = ~clk;

  eth_tx_slot dut (
    .gmii_tx_clk     (clk),
    .sys_rst         (sys_rst),
    .tx_start        (tx_start),
    .tx_frame_len    (tx_frame_len),
    .global_counter  (global_counter),
    .slot_tx_address (slot_tx_address),
    .slot_tx_q       (slot_tx_q),
    .gmii_txd        (gmii_txd),
    .gmii_tx_en      (gmii_tx_en),
    .tx_busy         (tx_busy),
    .tx_complete     (tx_complete),
    .tx_drop         (tx_drop),
    .tx_timestamp    (tx_timestamp)
  );

  int          cyc = 0;
  logic [63:0] gc_base = 64'd0;
  logic [31:0] mem [0:2047];

  // Slot RAM model: registered read, one cycle latency.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    slot_tx_q <= mem[slot_tx_address];
  end

  assign global_counter = gc_base + 64'(cyc);

  typedef struct { int cyc; logic [7:0] d; } byte_t;
  typedef struct { int cyc; bit drop; logic [63:0] ts; } ev_t;

  byte_t exp_q[$];
  ev_t   ev_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;

  function automatic logic [7:0] pat_byte(input int pat, input int n);
    if (pat == 0) return 8'(n);
    return 8'(n * 37 + 5);
  endfunction

  function automatic int body_len(input int len);
`ifdef ETH_TX_CRC_EN
    return ((len < 60) ? 60 : len) + 4;
`else
    return len;
`endif
  endfunction

`ifdef ETH_TX_CRC_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input int c, input logic [7:0] d);
    byte_t b;
    b.cyc = c;
    b.d   = d;
    exp_q.push_back(b);
  endtask

  // Loads the slot, issues tx_start in the current cycle t and queues every
  // expected GMII byte and the completion event. Returns in cycle t+1.
  task automatic send_frame(input int len, input int pat, output int t);
    ev_t         e;
    logic [7:0]  b;
`ifdef ETH_TX_CRC_EN
    logic [31:0] crc;
`endif
    for (int w = 0; w < (len + 3) / 4 + 1; w++) begin
      mem[w] = {pat_byte(pat, 4*w+3), pat_byte(pat, 4*w+2), pat_byte(pat, 4*w+1), pat_byte(pat, 4*w)};
    end
    t = cyc;
    tx_start     = 1'b1;
    tx_frame_len = 12'(len);
    for (int i = 0; i < PRE; i++) push_byte(t + 1 + i, 8'h55);
    push_byte(t + 1 + PRE, 8'hD5);
`ifdef ETH_TX_CRC_EN
    crc = 32'hFFFFFFFF;
`endif
    for (int n = 0; n < len; n++) begin
      b = pat_byte(pat, n);
      push_byte(t + 2 + PRE + n, b);
`ifdef ETH_TX_CRC_EN
      crc = crc_upd(crc, b);
`endif
    end
`ifdef ETH_TX_CRC_EN
    for (int n = len; n < 60; n++) begin
      push_byte(t + 2 + PRE + n, 8'h00);
      crc = crc_upd(crc, 8'h00);
    end
    crc = ~crc;
    for (int k = 0; k < 4; k++) push_byte(t + 2 + PRE + body_len(len) - 4 + k, crc[8*k +: 8]);
`endif
    e.cyc  = t + 1 + PRE + body_len(len) + IFG;
    e.drop = 1'b0;
    e.ts   = gc_base + 64'(t) + 64'(PRE + 1);
    ev_q.push_back(e);
    tick;
    tx_start     = 1'b0;
    tx_frame_len = 12'd0;
  endtask

  task automatic send_drop(input int len);
    ev_t e;
    e.cyc  = cyc + 1;
    e.drop = 1'b1;
    e.ts   = 64'd0;
    ev_q.push_back(e);
    tx_start     = 1'b1;
    tx_frame_len = 12'(len);
    tick;
    tx_start     = 1'b0;
    tx_frame_len = 12'd0;
    check("drop_busy_low", 64'(tx_busy), 64'd0);
    tick;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while ((tx_busy || exp_q.size() != 0 || ev_q.size() != 0) && k < limit) begin
      tick;
      k++;
    end
    n_cmp++;
    if (tx_busy || exp_q.size() != 0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL wait_done: busy=%0b bytes_left=%0d events_left=%0d after %0d cycles",
               tx_busy, exp_q.size(), ev_q.size(), limit);
      exp_q.delete();
      ev_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT drives a byte or an event.
  initial begin
    byte_t       mb;
    ev_t         me;
    bit          ok;
`ifdef ETH_TX_CRC_EN
    logic [31:0] m_crc;
    int          m_cnt;
    bit          m_prev_en;
    m_crc     = 32'hFFFFFFFF;
    m_cnt     = 0;
    m_prev_en = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (gmii_tx_en) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_byte: unexpected 0x%0h at cycle %0d", gmii_txd, cyc);
          end else begin
            mb = exp_q.pop_front();
            if (mb.cyc != cyc || mb.d !== gmii_txd) begin
              n_fail++;
              $display("FAIL tx_byte: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                       gmii_txd, cyc, mb.d, mb.cyc);
            end
          end
        end
        if (tx_complete || tx_drop) begin
          n_cmp++;
          if (ev_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_event: unexpected complete=%0b drop=%0b at cycle %0d", tx_complete, tx_drop, cyc);
          end else begin
            me = ev_q.pop_front();
            ok = (me.cyc == cyc) && tx_complete && (tx_drop == me.drop) &&
                 (me.drop || tx_timestamp == me.ts);
            if (!ok) begin
              n_fail++;
              $display("FAIL tx_event: got complete=%0b drop=%0b ts=0x%0h at cycle %0d expected drop=%0b ts=0x%0h at cycle %0d",
                       tx_complete, tx_drop, tx_timestamp, cyc, me.drop, me.ts, me.cyc);
            end
          end
        end
`ifdef ETH_TX_CRC_EN
        // Receiver view: CRC over everything after the SFD, FCS included.
        if (gmii_tx_en) begin
          if (m_cnt >= PRE + 1) m_crc = crc_upd(m_crc, gmii_txd);
          m_cnt++;
        end else if (m_prev_en) begin
          if (m_cnt > PRE + 1) begin
            n_cmp++;
            if (bitrev(m_crc) != 32'hC704DD7B) begin
              n_fail++;
              $display("FAIL fcs_residue: got 0x%0h expected 0xc704dd7b at cycle %0d", bitrev(m_crc), cyc);
            end
          end
          m_cnt = 0;
          m_crc = 32'hFFFFFFFF;
        end
        if (sys_rst) m_cnt = 0;
        m_prev_en = gmii_tx_en;
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int t2;
    int fall;
    sys_rst      = 1'b1;
    tx_start     = 1'b0;
    tx_frame_len = 12'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    repeat (3) tick;

    check("rst_tx_en",     64'(gmii_tx_en), 64'd0);
    check("rst_txd",       64'(gmii_txd), 64'd0);
    check("rst_busy",      64'(tx_busy), 64'd0);
    check("rst_complete",  64'(tx_complete), 64'd0);
    check("rst_drop",      64'(tx_drop), 64'd0);
    check("rst_timestamp", tx_timestamp, 64'd0);
    check("rst_address",   64'(slot_tx_address), 64'd0);

    sys_rst = 1'b0;
    mon_en  = 1'b1;
    tick;

    // Basic 64-byte frame with timestamp base 0x1000 at the start cycle.
    gc_base = 64'h1000 - 64'(cyc);
    send_frame(64, 0, t);
    check("busy_after_start", 64'(tx_busy), 64'd1);
    wait_done(300);
    check("timestamp", tx_timestamp, 64'h1008);

    // Odd length, short frame, minimum length.
    gc_base = 64'h0123_4567_89AB_0000;
    send_frame(61, 1, t);
    wait_done(300);
    send_frame(14, 1, t);
    wait_done(300);
    send_frame(1, 1, t);
    wait_done(300);

    // Rejected lengths.
    send_drop(0);
    send_drop(1519);
    wait_done(20);

    // tx_start while busy is ignored, including an invalid length.
    send_frame(32, 1, t);
    repeat (14) tick;
    tx_start = 1'b1; tx_frame_len = 12'd20;
    tick;
    tx_start = 1'b0; tx_frame_len = 12'd0;
    tick;
    tx_start = 1'b1; tx_frame_len = 12'd0;
    tick;
    tx_start = 1'b0;
    wait_done(300);

    // New request in the very cycle tx_busy falls.
    send_frame(8, 0, t);
    fall = t + 2 + PRE + body_len(8) + IFG;
    while (cyc < fall - 1) tick;
    check("busy_last_ifg", 64'(tx_busy), 64'd1);
    tick;
    check("busy_fall_cycle", 64'(tx_busy), 64'd0);
    send_frame(5, 1, t2);
    check("busy_back_to_back", 64'(tx_busy), 64'd1);
    wait_done(300);

    // One-cycle reset in the middle of DATA, then a fresh frame.
    send_frame(64, 1, t);
    while (cyc < t + 20) tick;
    sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    exp_q.delete();
    ev_q.delete();
    check("rst_mid_tx_en", 64'(gmii_tx_en), 64'd0);
    check("rst_mid_busy",  64'(tx_busy), 64'd0);
    repeat (30) tick;
    send_frame(20, 0, t);
    wait_done(300);

    // Largest accepted frame.
    send_frame(1518, 0, t);
    wait_done(2000);

    check("queues_empty", 64'(exp_q.size() + ev_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
